// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone port arbiter.
// Imported by the arbiter top and its round-robin helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS0 = 2'd1,
    BUS1 = 2'd2,
    TOUT = 2'd3
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam logic        M0           = 1'b0;
  localparam logic        M1           = 1'b1;
  localparam int unsigned CNT_W        = 10;

endpackage

// File: rtl/wb_arb_rr.sv
// Two-way round-robin pointer and grant decision.
// The pointer holds the last owner; ties go to the other master.
module wb_arb_rr
  import wb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (upd_i) last_d = upd_idx_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= M1;
    else        last_q <= last_d;
  end

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = M0;
    unique case (1'b1)
      &req_i:               gnt_idx_o = ~last_q;
      req_i[1] & ~req_i[0]: gnt_idx_o = M1;
      default:              gnt_idx_o = M0;
    endcase
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates two Wishbone masters onto one slave port with a
// slave-wait timeout that forces an error acknowledge.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [1:0]  m_we_i,
  input  logic [7:0]  m_sel_i,
  input  logic [63:0] m_adr_i,
  input  logic [63:0] m_dat_i,
  output logic [1:0]  m_ack_o,
  output logic [63:0] m_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic             tout_q, tout_d;

  logic [1:0] req;
  logic       rr_vld;
  logic       rr_idx;
  logic       rr_upd;
  logic       own_cyc;
  logic [5:0] base;
  logic [2:0] sbase;

  assign req     = m_cyc_i & m_stb_i;
  assign own_cyc = m_cyc_i[owner_q];
  assign base    = {owner_q, 5'd0};
  assign sbase   = {owner_q, 2'd0};

  wb_arb_rr u_rr (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .req_i     (req),
    .upd_i     (rr_upd),
    .upd_idx_i (owner_q),
    .gnt_vld_o (rr_vld),
    .gnt_idx_o (rr_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_upd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rr_vld) begin
          owner_d = rr_idx;
          state_d = rr_idx ? BUS1 : BUS0;
        end
      end
      BUS0, BUS1: begin
        if (!own_cyc) begin
          rr_upd  = 1'b1;
          state_d = IDLE;
        end else if (s_stb_o && !s_ack_i
                     && cnt_q == CNT_MAX) begin
          state_d = TOUT;
        end
      end
      TOUT: begin
        if (own_cyc) state_d = owner_q ? BUS1 : BUS0;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait counter restarts on any state change, ack or idle strobe.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_d != state_q || s_ack_i || !s_stb_o)
      cnt_d = '0;
  end

  always_comb begin
    grant_d = 2'b00;
    unique case (state_d)
      BUS0:    grant_d = 2'b01;
      BUS1:    grant_d = 2'b10;
      TOUT:    grant_d = owner_d ? 2'b10 : 2'b01;
      default: grant_d = 2'b00;
    endcase
    tout_d = (state_d == TOUT);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      owner_q <= M0;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_dat_o = '0;
    unique case (state_q)
      BUS0, BUS1: begin
        s_cyc_o = own_cyc;
        s_stb_o = own_cyc & m_stb_i[owner_q];
        s_we_o  = m_we_i[owner_q];
        s_sel_o = m_sel_i[sbase +: 4];
        s_adr_o = m_adr_i[base +: 32];
        s_dat_o = m_dat_i[base +: 32];
        m_ack_o[owner_q]    = s_ack_i & own_cyc;
        m_dat_o[base +: 32] = s_dat_i;
      end
      TOUT: begin
        m_ack_o[owner_q]    = 1'b1;
        m_dat_o[base +: 32] = TIMEOUT_DATA;
      end
      default: ;
    endcase
  end

  assign grant_o   = grant_q;
  assign timeout_o = tout_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: per-master read queues,
// a latency-programmable slave model and a per-cycle bus monitor.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;

  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [7:0]  m_sel_i;
  logic [63:0] m_adr_i, m_dat_i;
  logic [1:0]  m_ack_o;
  logic [63:0] m_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i = 1'b0;
  logic [31:0] s_dat_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  assign m_cyc_i = {m1_cyc, m0_cyc};
  assign m_stb_i = {m1_stb, m0_stb};
  assign m_we_i  = {m1_we, m0_we};
  assign m_sel_i = {m1_sel, m0_sel};
  assign m_adr_i = {m1_adr, m0_adr};
  assign m_dat_i = {m1_dat, m0_dat};
  assign s_dat_i = ~s_adr_o;

  wb_port_arbiter #(.TIMEOUT(TO)) dut (
    .wb_clk_i (clk),     .wb_rst_ni (rst_n),
    .m_cyc_i  (m_cyc_i), .m_stb_i   (m_stb_i),
    .m_we_i   (m_we_i),  .m_sel_i   (m_sel_i),
    .m_adr_i  (m_adr_i), .m_dat_i   (m_dat_i),
    .m_ack_o  (m_ack_o), .m_dat_o   (m_dat_o),
    .s_cyc_o  (s_cyc_o), .s_stb_o   (s_stb_o),
    .s_we_o   (s_we_o),  .s_sel_o   (s_sel_o),
    .s_adr_o  (s_adr_o), .s_dat_o   (s_dat_o),
    .s_ack_i  (s_ack_i), .s_dat_i   (s_dat_i),
    .grant_o  (grant_o), .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit done;
  int lat;
  time req_t, stb_t, m0_ack_t, m1_ack_t, g10_t;
  logic [1:0] first_g;
  logic [31:0] stb_adr;
  int to_n;

  task automatic set_m(input int x, input logic c, input logic s,
                       input logic [31:0] a);
    if (x == 0) begin
      m0_cyc = c; m0_stb = s; m0_we = 1'b0;
      m0_sel = 4'hF; m0_adr = a; m0_dat = ~a;
    end else begin
      m1_cyc = c; m1_stb = s; m1_we = 1'b0;
      m1_sel = 4'hF; m1_adr = a; m1_dat = ~a;
    end
  endtask

  task automatic master(input int x, input int n,
                        input logic [31:0] b, input int dly,
                        input bit to);
    logic [31:0] a, e, got;
    int w;
    repeat (dly + 1) @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      a = b + 32'(4 * i);
      set_m(x, 1'b1, 1'b1, a);
      if (req_t == 0) req_t = $time;
      e = to ? TIMEOUT_DATA : ~a;
      if (x == 0) q0.push_back(e);
      else        q1.push_back(e);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!m_ack_o[x] && w < 100);
      got = m_dat_o[32*x +: 32];
      e = (x == 0) ? q0.pop_front() : q1.pop_front();
      total++;
      if (m_ack_o[x] !== 1'b1 || got !== e) begin
        bad++;
        $display("FAIL m%0d_read%0d: ack=%b data=%h, want ack=1 data=%h",
                 x, i, m_ack_o[x], got, e);
      end
      if (x == 0) m0_ack_t = $time;
      else if (m1_ack_t == 0) m1_ack_t = $time;
      @(posedge clk);
      #1;
    end
    set_m(x, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic slave();
    int w = 0;
    while (!done) begin
      @(posedge clk);
      #2;
      if (s_cyc_o && s_stb_o) begin
        if (lat >= 0 && w == lat) begin
          s_ack_i = 1'b1; w = 0;
        end else begin
          s_ack_i = 1'b0; w++;
        end
      end else begin
        s_ack_i = 1'b0; w = 0;
      end
    end
    s_ack_i = 1'b0;
  endtask

  task automatic monitor();
    while (!done) begin
      @(negedge clk);
      total++;
      if (grant_o === 2'b11) begin
        bad++;
        $display("FAIL grant_onehot: grant=%b, want not 11", grant_o);
      end
      for (int x = 0; x < 2; x++) begin
        if (grant_o[x] === 1'b0) begin
          total++;
          if (m_ack_o[x] !== 1'b0 || m_dat_o[32*x +: 32] !== 32'h0) begin
            bad++;
            $display("FAIL idle_m%0d: ack=%b data=%h, want 0/0",
                     x, m_ack_o[x], m_dat_o[32*x +: 32]);
          end
        end
      end
      if (s_stb_o && stb_t == 0) begin
        stb_t = $time;
        stb_adr = s_adr_o;
      end
      if (grant_o != 2'b00 && first_g == 2'b00) first_g = grant_o;
      if (grant_o == 2'b10 && g10_t == 0) g10_t = $time;
      if (timeout_o) begin
        to_n++;
        total++;
        if (m_ack_o !== grant_o) begin
          bad++;
          $display("FAIL tout_ack: ack=%b, want %b", m_ack_o, grant_o);
        end
      end
    end
  endtask

  task automatic run(input int n0, input logic [31:0] b0, input int d0,
                     input int n1, input logic [31:0] b1, input int d1,
                     input int l, input bit to);
    done = 0; lat = l; req_t = 0; stb_t = 0; stb_adr = 0;
    m0_ack_t = 0; m1_ack_t = 0; g10_t = 0; first_g = 0; to_n = 0;
    fork
      begin
        fork
          if (n0 > 0) master(0, n0, b0, d0, to);
          if (n1 > 0) master(1, n1, b1, d1, to);
        join
        repeat (3) @(posedge clk);
        #1 done = 1;
      end
      slave();
      monitor();
    join
  endtask

  task automatic check(input string nm, input longint got,
                       input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_m(0, 1'b1, 1'b1, 32'h1234_5678);
    set_m(1, 1'b1, 1'b1, 32'h8765_4320);
    repeat (2) @(negedge clk);
    total++;
    if ({grant_o, timeout_o, s_cyc_o, s_stb_o, s_we_o} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: grant=%b tout=%b cyc=%b stb=%b we=%b, want 0",
               grant_o, timeout_o, s_cyc_o, s_stb_o, s_we_o);
    end
    total++;
    if ({s_sel_o, s_adr_o, s_dat_o, m_ack_o, m_dat_o} !== '0) begin
      bad++;
      $display("FAIL reset_data: sel=%h adr=%h dat=%h ack=%b mdat=%h, want 0",
               s_sel_o, s_adr_o, s_dat_o, m_ack_o, m_dat_o);
    end
    set_m(0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    run(1, 32'h3000_0004, 0, 0, 32'h0, 0, 2, 1'b0);
    check("arb_latency", (stb_t - req_t) / 10, 1);
    check("ack_cycles", (m0_ack_t - stb_t) / 10 + 1, 3);
    check("stb_adr", stb_adr, 32'h3000_0004);
    check("single_grant", first_g, 2'b01);
  endtask

  task automatic test_simultaneous();
    do_reset();
    run(1, 32'h1000_0000, 0, 1, 32'h2000_0000, 0, 1, 1'b0);
    check("sim_first_grant", first_g, 2'b01);
    check("sim_m1_after_m0", (g10_t > m0_ack_t) ? 1 : 0, 1);
  endtask

  task automatic test_back_to_back();
    run(3, 32'h3000_0100, 0, 1, 32'h2000_0040, 1, 1, 1'b0);
    check("b2b_first_grant", first_g, 2'b01);
    check("b2b_m1_ack_after", (m1_ack_t > m0_ack_t) ? 1 : 0, 1);
    check("b2b_m1_grant_after", (g10_t > m0_ack_t) ? 1 : 0, 1);
  endtask

  task automatic test_timeout();
    run(0, 32'h0, 0, 1, 32'h2000_0080, 0, -1, 1'b1);
    check("tout_cycles", (m1_ack_t - stb_t) / 10 + 1, 9);
    check("tout_pulses", to_n, 1);
    check("tout_grant", first_g, 2'b10);
  endtask

  task automatic test_ack_race();
    run(1, 32'h3000_0200, 0, 0, 32'h0, 0, int'(TO) - 1, 1'b0);
    check("race_pulses", to_n, 0);
    check("race_cycles", (m0_ack_t - stb_t) / 10 + 1, int'(TO));
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    set_m(1, 1'b1, 1'b1, 32'h2000_0100);
    repeat (3) @(negedge clk);
    check("mid_grant", grant_o, 2'b10);
    check("mid_adr", s_stb_o ? s_adr_o : 32'h0, 32'h2000_0100);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({grant_o, timeout_o, s_cyc_o, s_stb_o, s_adr_o, m_ack_o, m_dat_o}
        !== '0) begin
      bad++;
      $display("FAIL mid_reset_out: grant=%b cyc=%b stb=%b adr=%h ack=%b mdat=%h, want 0",
               grant_o, s_cyc_o, s_stb_o, s_adr_o, m_ack_o, m_dat_o);
    end
    set_m(1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    set_m(0, 1'b1, 1'b1, 32'h3000_0300);
    set_m(1, 1'b1, 1'b1, 32'h2000_0300);
    @(negedge clk);
    check("post_rst_idle", grant_o, 2'b00);
    @(negedge clk);
    check("post_rst_grant", grant_o, 2'b01);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    set_m(0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    test_ack_race();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
